fft32_bfly_sched: RTL

Sequencer for the single shared radix-2 butterfly MAC in the serial 32-point FFT. It walks 5 DIT stages x 16 butterflies in place, one butterfly issued per cycle. It drives the data-RAM read/write addresses, the twiddle-ROM index and the write-back strobes, and inserts drain gaps between stages so that stage s+1 never reads a word before stage s has written it. Input data is already bit-reversed in RAM; the butterfly and RAM datapaths are external to this block.

---
 rtl/fft32_pkg.sv | 15 +
 rtl/fft32_bfly_addr_gen.sv | 26 ++
 rtl/fft32_bfly_sched.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fft32_pkg.sv
// Shared constants and FSM state type for the serial 32-point FFT butterfly scheduler.
package fft32_pkg;
  localparam int N_POINTS       = 32;
  localparam int LOG2N          = 5;
  localparam int ADDR_W         = 5;
  localparam int TW_W           = 4;
  localparam int BFLY_PER_STAGE = N_POINTS / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/fft32_bfly_addr_gen.sv
// Combinational DIT address map: (stage, butterfly index) -> operand pair and twiddle index.
module fft32_bfly_addr_gen
  import fft32_pkg::*;
(
  input  logic [2:0]        stage,
  input  logic [TW_W-1:0]   k,
  output logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] b,
  output logic [TW_W-1:0]   tw
);

  logic [ADDR_W-1:0] half;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] grp;

  always_comb begin
    half = ADDR_W'(1) << stage;
    pos  = {1'b0, k} & (half - ADDR_W'(1));
    grp  = {1'b0, k} >> stage;
    a    = (grp << (stage + 3'd1)) + pos;
    b    = a + half;
    // pos < half, so the scaled index always lands inside the 16-entry ROM
    tw   = TW_W'(pos << (3'(LOG2N - 1) - stage));
  end

endmodule

// File: rtl/fft32_bfly_sched.sv
// Issue/write-back sequencer for the shared radix-2 butterfly of the serial 32-point FFT.
// Optional macro FFT_INVERSE_EN adds the inverse input and tw_conj output.
module fft32_bfly_sched
  import fft32_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef FFT_INVERSE_EN
  input  logic              inverse,
`endif
  output logic              busy,
  output logic              done,
  output logic [2:0]        stage,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [TW_W-1:0]   tw_addr,
`ifdef FFT_INVERSE_EN
  output logic              tw_conj,
`endif
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b
);

  localparam int PIPE_LAT = RD_LAT + MAC_LAT;
  localparam int DRN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t            state;
  logic [TW_W-1:0]   k;
  logic [2:0]        stage_q;
  logic [DRN_W-1:0]  drn;
  logic              issue;
  logic [ADDR_W-1:0] a_c;
  logic [ADDR_W-1:0] b_c;
  logic [TW_W-1:0]   tw_c;

  logic [PIPE_LAT-1:0] vld_p;
  logic [ADDR_W-1:0]   wa_p [PIPE_LAT];
  logic [ADDR_W-1:0]   wb_p [PIPE_LAT];

  fft32_bfly_addr_gen u_addr_gen (
    .stage (stage_q),
    .k     (k),
    .a     (a_c),
    .b     (b_c),
    .tw    (tw_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      stage_q <= '0;
      drn     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            k       <= '0;
            stage_q <= '0;
          end
        end
        RUN: begin
          k <= k + 1'b1;
          if (k == TW_W'(BFLY_PER_STAGE - 1)) begin
            state <= DRAIN;
            drn   <= '0;
          end
        end
        DRAIN: begin
          drn <= drn + 1'b1;
          // The gap lets the last write of this stage land before the next stage reads
          if (drn == DRN_W'(PIPE_LAT - 1)) begin
            drn <= '0;
            if (stage_q == 3'(LOG2N - 1)) begin
              state <= DONE;
            end else begin
              stage_q <= stage_q + 1'b1;
              state   <= RUN;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          stage_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign issue     = (state == RUN);
  assign rd_en     = issue;
  assign busy      = issue || (state == DRAIN);
  assign done      = (state == DONE);
  assign stage     = stage_q;
  assign rd_addr_a = issue ? a_c : '0;
  assign rd_addr_b = issue ? b_c : '0;
  assign tw_addr   = issue ? tw_c : '0;

`ifdef FFT_INVERSE_EN
  logic inv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else if ((state == IDLE) && start) begin
      inv_q <= inverse;
    end
  end

  assign tw_conj = issue & inv_q;
`endif

  // Write-back delay line: stage p0 is one cycle after issue
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    wa_p[0] <= a_c;
    wb_p[0] <= b_c;
    for (int i = 1; i < PIPE_LAT; i++) begin
      wa_p[i] <= wa_p[i-1];
      wb_p[i] <= wb_p[i-1];
    end
  end

  assign wr_en     = vld_p[PIPE_LAT-1];
  assign wr_addr_a = wr_en ? wa_p[PIPE_LAT-1] : '0;
  assign wr_addr_b = wr_en ? wb_p[PIPE_LAT-1] : '0;

endmodule
